// File: rtl/freq_div_pkg.sv
// Shared definitions for the frequency-divider configuration sequencer:
// FSM state encoding, the bypass divisor value and the default divisor width.
package freq_div_pkg;

    localparam int DEF_DATA_W = 32;

    // Divisor value that makes the divider pass clk straight through.
    localparam int DIV_BYPASS = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HALT   = 2'd1,
        LOAD   = 2'd2,
        COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/freq_div_cfg_ctrl.sv
// Configuration sequencer in front of the frequency divider.
// Accepts a divisor over valid/ready and drives the divider pins in the order
// halt -> load -> commit -> resume, owning the running state of the divided clock.
// Optional build macro: FREQ_DIV_CFG_RANGE_CHECK_EN rejects non-zero divisors
// outside [MIN_DIV, MAX_DIV] with a one-cycle err pulse instead of loading them.
module freq_div_cfg_ctrl
    import freq_div_pkg::*;
#(
    parameter int                DATA_W        = DEF_DATA_W,
    parameter int                SETTLE_CYCLES = 2,
    parameter logic [DATA_W-1:0] MIN_DIV       = DATA_W'(2),
    parameter logic [DATA_W-1:0] MAX_DIV       = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [DATA_W-1:0] req_div,
    output logic              req_ready,
    input  logic              run_en,
    output logic              enable,
    output logic              configDiv,
    output logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              cfg_done,
    output logic [DATA_W-1:0] cur_div,
    output logic              err
);

    // Elaboration-time sanity checks on the configuration.
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must lie in 1..15");
    end
    if (MIN_DIV > MAX_DIV) begin : g_bad_range
        $error("MIN_DIV must not exceed MAX_DIV");
    end

    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [DATA_W-1:0] BYPASS_VAL  = DATA_W'(DIV_BYPASS);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [DATA_W-1:0] cap, cap_nxt;
    logic [DATA_W-1:0] din_nxt, cur_nxt;
    logic              enable_nxt, config_nxt, done_nxt, err_nxt;
    logic              reject, accept;

    assign req_ready = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);

`ifdef FREQ_DIV_CFG_RANGE_CHECK_EN
    // Bypass is always legal; any other value must sit inside the legal range.
    assign reject = req_valid && req_ready && (req_div != BYPASS_VAL) &&
                    ((req_div < MIN_DIV) || (req_div > MAX_DIV));
`else
    assign reject = 1'b0;
`endif
    assign accept = req_valid && req_ready && !reject;

    // State and all registered outputs; reset discards any captured divisor.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cap       <= BYPASS_VAL;
            enable    <= 1'b0;
            configDiv <= 1'b0;
            din       <= BYPASS_VAL;
            cur_div   <= BYPASS_VAL;
            cfg_done  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cap       <= cap_nxt;
            enable    <= enable_nxt;
            configDiv <= config_nxt;
            din       <= din_nxt;
            cur_div   <= cur_nxt;
            cfg_done  <= done_nxt;
            err       <= err_nxt;
        end
    end

    // Next-state and next-output decode; outputs are set one state ahead so the
    // registered pins line up with the state they belong to.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cap_nxt    = cap;
        enable_nxt = enable;
        config_nxt = 1'b0;
        din_nxt    = din;
        cur_nxt    = cur_div;
        done_nxt   = 1'b0;
        err_nxt    = reject;
        case (state)
            IDLE: begin
                enable_nxt = run_en;
                if (accept) begin
                    cap_nxt    = req_div;
                    enable_nxt = 1'b0;
                    state_nxt  = HALT;
                end else if (reject) begin
                    enable_nxt = enable;
                end
            end
            HALT: begin
                // Divided clock is already stopped; present the divisor next.
                enable_nxt = 1'b0;
                config_nxt = 1'b1;
                din_nxt    = cap;
                state_nxt  = LOAD;
            end
            LOAD: begin
                enable_nxt = 1'b0;
                cnt_nxt    = 4'd0;
                state_nxt  = COMMIT;
            end
            COMMIT: begin
                enable_nxt = 1'b0;
                if (cnt == SETTLE_LAST) begin
                    cur_nxt    = cap;
                    done_nxt   = 1'b1;
                    enable_nxt = run_en;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
